// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the reset/clock-enable sequencer.
// The stage counter width is derived from the longer of the hold and gap intervals.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_REL_MEM  = 3'd1,
    ST_REL_CORE = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  localparam int HOLD_CYCLES_DEF = 16;
  localparam int STAGE_GAP_DEF   = 4;
  localparam int DIV_W_DEF       = 5;
  localparam int DIV_MAX_DEF     = 24;
  localparam int DIV_DEFAULT_DEF = 0;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop synchronizer: asserts asynchronously with resetn, releases on the second clock edge.
module reset_sync (
  input  logic clk,
  input  logic resetn,
  output logic rst_sync
);

  logic meta_r;

  // Shift a one through two flops after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_r   <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      meta_r   <= 1'b1;
      rst_sync <= meta_r;
    end
  end

endmodule

// File: rtl/reset_clock_ctrl.sv
// Staged reset release (mem -> core -> periph), software core reset, and a
// power-of-two core clock-enable generator with a run-time programmable exponent.
module reset_clock_ctrl
  import clk_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_MAX     = DIV_MAX_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [DIV_W-1:0] div_q,
  output logic             mem_rstn,
  output logic             core_rstn,
  output logic             periph_rstn,
  output logic             core_ce,
  output logic             ready
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [DIV_W-1:0] DIV_CLAMP = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_DEFAULT);

  logic               rst_sync;
  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               mem_s, core_s, periph_s, ready_s, ack_s;
  logic [DIV_W-1:0]   div_s;
  logic [DIV_MAX-1:0] pre_r, idx_s, mask_s;
  logic               ce_s;

  reset_sync u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .rst_sync (rst_sync)
  );

  // Sequencer next-state: one shared counter times every stage interval.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r + CW'(1);
    mem_s    = mem_rstn;
    core_s   = core_rstn;
    periph_s = periph_rstn;
    ready_s  = ready;
    ack_s    = 1'b0;
    case (state_r)
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_REL_MEM;
          cnt_s   = '0;
          mem_s   = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_REL_MEM: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_REL_CORE;
          cnt_s   = '0;
          core_s  = 1'b1;
        end else begin
          state_s = ST_REL_MEM;
        end
      end
      ST_REL_CORE: begin
        if (cnt_r == GAP_LAST) begin
          state_s  = ST_RUN;
          cnt_s    = '0;
          periph_s = 1'b1;
          ready_s  = 1'b1;
        end else begin
          state_s = ST_REL_CORE;
        end
      end
      ST_RUN: begin
        cnt_s = '0;
        if (sw_rst_req) begin
          state_s  = ST_DRAIN;
          core_s   = 1'b0;
          periph_s = 1'b0;
          ready_s  = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Core re-release and the ack share the final drain edge.
        if (cnt_r == GAP_LAST) begin
          state_s = ST_REL_CORE;
          cnt_s   = '0;
          core_s  = 1'b1;
          ack_s   = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s  = ST_HOLD;
        cnt_s    = '0;
        mem_s    = 1'b0;
        core_s   = 1'b0;
        periph_s = 1'b0;
        ready_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and reset outputs.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_r     <= ST_HOLD;
      cnt_r       <= '0;
      mem_rstn    <= 1'b0;
      core_rstn   <= 1'b0;
      periph_rstn <= 1'b0;
      ready       <= 1'b0;
      sw_rst_ack  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mem_rstn    <= mem_s;
      core_rstn   <= core_s;
      periph_rstn <= periph_s;
      ready       <= ready_s;
      sw_rst_ack  <= ack_s;
    end
  end

  // Divider exponent, prescaler index of the upcoming cycle and its pulse mask.
  always_comb begin
    if (cfg_we) begin
      div_s = (cfg_div > DIV_CLAMP) ? DIV_CLAMP : cfg_div;
    end else begin
      div_s = div_q;
    end
    mask_s = '0;
    for (int i = 0; i < DIV_MAX; i++) begin
      mask_s[i] = (i < int'(div_s));
    end
    if (!core_s) begin
      idx_s = '0;
    end else if (cfg_we) begin
      idx_s = '0;
    end else if (core_rstn) begin
      idx_s = pre_r + DIV_MAX'(1);
    end else begin
      idx_s = '0;
    end
    ce_s = core_s && ((idx_s & mask_s) == mask_s);
  end

  // Divider register, prescaler and registered clock-enable.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      div_q   <= DIV_RST;
      pre_r   <= '0;
      core_ce <= 1'b0;
    end else begin
      div_q   <= div_s;
      pre_r   <= idx_s;
      core_ce <= ce_s;
    end
  end

endmodule

// File: tb/tb_reset_clock_ctrl.sv
// Randomized bench for reset_clock_ctrl against an event-time reference model
// (release edges and pulse arithmetic), built with a short prescaler (DIV_MAX=6).
module tb_reset_clock_ctrl;

  localparam int H  = 16;
  localparam int S  = 4;
  localparam int DW = 5;
  localparam int DM = 6;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic          sw_rst_ack;
  logic          cfg_we = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] div_q;
  logic          mem_rstn, core_rstn, periph_rstn, core_ce, ready;

  int checks = 0;
  int failures = 0;

  // Model: edge count since release and the edges at which each event happens.
  int n, mem_at, core_at, periph_at, ack_at, last_we, dq;

  always #5 clk = ~clk;

  reset_clock_ctrl #(
    .HOLD_CYCLES (H),
    .STAGE_GAP   (S),
    .DIV_W       (DW),
    .DIV_MAX     (DM),
    .DIV_DEFAULT (0)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .cfg_we      (cfg_we),
    .cfg_div     (cfg_div),
    .div_q       (div_q),
    .mem_rstn    (mem_rstn),
    .core_rstn   (core_rstn),
    .periph_rstn (periph_rstn),
    .core_ce     (core_ce),
    .ready       (ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; mem_at = NEVER; core_at = NEVER; periph_at = NEVER;
    ack_at = -100; last_we = -100; dq = 0;
  endtask

  task automatic model_init();
    n = 0; mem_at = 2 + H; core_at = mem_at + S; periph_at = core_at + S;
    ack_at = -100; last_we = -100; dq = 0;
  endtask

  task automatic check_outputs();
    int  base;
    bit  c;
    bit  ce;
    c    = (n >= core_at);
    base = (core_at > last_we) ? core_at : last_we;
    ce   = c && (((n - base + 1) % (1 << dq)) == 0);
    check_eq("mem_rstn",    mem_rstn,    n >= mem_at);
    check_eq("core_rstn",   core_rstn,   c);
    check_eq("periph_rstn", periph_rstn, n >= periph_at);
    check_eq("ready",       ready,       n >= periph_at);
    check_eq("sw_rst_ack",  sw_rst_ack,  n == ack_at);
    check_eq("div_q",       div_q,       dq);
    check_eq("core_ce",     core_ce,     ce);
  endtask

  task automatic step(input bit req, input bit we, input int div);
    sw_rst_req = req;
    cfg_we     = we;
    cfg_div    = DW'(div);
    @(posedge clk);
    n++;
    if (req && (n - 1 >= periph_at)) begin
      core_at   = n + S;
      periph_at = n + 2 * S;
      ack_at    = n + S;
    end
    if (we && n >= 3) begin
      dq      = (div > DM) ? DM : div;
      last_we = n;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int k);
    sw_rst_req = 1'b0;
    cfg_we     = 1'b0;
    resetn     = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    #3;
    resetn = 1'b1;
    model_init();
  endtask

  task automatic run_random(input int cycles, input int req_mod, input int we_mod);
    for (int i = 0; i < cycles; i++) begin
      step(($urandom % req_mod) == 0, ($urandom % we_mod) == 0, int'($urandom % 32));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    do_reset(3);

    // Power-on release with spurious requests during HOLD/REL stages.
    for (int i = 0; i < 30; i++) begin
      step(($urandom % 4) == 0, 1'b0, 0);
    end

    // Exponent 3: pulse every 8 cycles, first on the 8th after the write.
    step(1'b0, 1'b1, 3);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 0);

    // Oversized write clamps; the full-width exponent exercises prescaler wrap.
    step(1'b0, 1'b1, 31);
    check_eq("div_clamp", div_q, DM);
    for (int i = 0; i < 140; i++) step(1'b0, 1'b0, 0);

    // SW reset with coincident divider write, plus requests during DRAIN.
    step(1'b1, 1'b1, 2);
    check_eq("mem_held", mem_rstn, 1'b1);
    for (int i = 0; i < 12; i++) step(($urandom % 2) == 0, 1'b0, 0);

    run_random(400, 25, 20);

    // Reach RUN, request a SW reset, then assert resetn in the middle of DRAIN.
    for (int i = 0; i < 20 && !(n - 1 >= periph_at); i++) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    #2;
    do_reset(2);
    check_eq("div_after_rst", div_q, 0);
    for (int i = 0; i < 30; i++) step(($urandom % 4) == 0, 1'b0, 0);
    run_random(200, 15, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
